// File: rtl/bpu_btb_gshare_ras.sv
// Pre-decode branch predictor: fully associative BTB, gshare PHT and a
// speculative/committed return address stack, with a registered lookup result.
module bpu_btb_gshare_ras #(
    parameter int BTB_NUM   = 16,
    parameter int TAG_WID   = 12,
    parameter int GHR_WID   = 8,
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_taken,
    output logic [31:0] resp_target,
    output logic        resp_btb_hit,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [1:0]  upd_type,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush
);
    localparam int BI_W  = $clog2(BTB_NUM);
    localparam int RP_W  = $clog2(RAS_DEPTH);
    localparam int CW    = RP_W + 1;
    localparam int PHT_N = 1 << GHR_WID;
    localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);
    localparam logic [1:0] T_COND = 2'd0, T_JUMP = 2'd1, T_CALL = 2'd2;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [RP_W-1:0] ras_ptr(input logic [RP_W-1:0] p, input logic [CW-1:0] c,
                                                 input logic push, input logic pop);
        if (push) return p + RP_W'(1);
        if (pop && c != '0) return p - RP_W'(1);
        return p;
    endfunction

    function automatic logic [CW-1:0] ras_cnt(input logic [CW-1:0] c, input logic push, input logic pop);
        if (push) return (c == RAS_FULL) ? c : c + CW'(1);
        if (pop && c != '0) return c - CW'(1);
        return c;
    endfunction

    logic [BTB_NUM-1:0] btb_vld;
    logic [TAG_WID-1:0] btb_tag [BTB_NUM];
    logic [1:0]         btb_type [BTB_NUM];
    logic [31:0]        btb_tgt [BTB_NUM];
    logic [BI_W-1:0]    victim;
    logic [1:0]         pht [PHT_N];
    logic [GHR_WID-1:0] ghr;
    logic [31:0]        s_mem [RAS_DEPTH];
    logic [31:0]        c_mem [RAS_DEPTH];
    logic [RP_W-1:0]    s_ptr, c_ptr, s_top_idx;
    logic [CW-1:0]      s_cnt, c_cnt;

    // Stage p0: combinational lookup on req_pc against pre-update state
    logic               hit_p0, taken_p0, push_p0, pop_p0, acc;
    logic [BI_W-1:0]    hidx_p0;
    logic [GHR_WID-1:0] pidx_p0;
    logic [31:0]        tgt_p0, req_pc4, s_top;

    assign req_pc4   = req_pc + 32'd4;
    assign pidx_p0   = ghr ^ req_pc[GHR_WID+1:2];
    assign s_top_idx = s_ptr - RP_W'(1);
    assign s_top     = s_mem[s_top_idx];
    assign req_ready = (!resp_valid || resp_ready) && !flush;
    assign acc       = req_valid && req_ready;

    always_comb begin
        hit_p0  = 1'b0;
        hidx_p0 = '0;
        for (int i = 0; i < BTB_NUM; i++) begin
            if (btb_vld[i] && btb_tag[i] == req_pc[TAG_WID+1:2]) begin
                hit_p0  = 1'b1;
                hidx_p0 = BI_W'(i);
            end
        end
    end

    always_comb begin
        taken_p0 = 1'b0;
        tgt_p0   = req_pc4;
        push_p0  = 1'b0;
        pop_p0   = 1'b0;
        if (hit_p0) begin
            case (btb_type[hidx_p0])
                T_COND: begin
                    taken_p0 = pht[pidx_p0][1];
                    if (taken_p0) tgt_p0 = btb_tgt[hidx_p0];
                end
                T_JUMP: begin
                    taken_p0 = 1'b1;
                    tgt_p0   = btb_tgt[hidx_p0];
                end
                T_CALL: begin
                    taken_p0 = 1'b1;
                    tgt_p0   = btb_tgt[hidx_p0];
                    push_p0  = 1'b1;
                end
                default: begin
                    taken_p0 = 1'b1;
                    pop_p0   = 1'b1;
                    tgt_p0   = (s_cnt != '0) ? s_top : btb_tgt[hidx_p0];
                end
            endcase
        end
    end

    // Training: BTB hit/allocation selection
    logic            u_hit, u_free, u_alloc, u_we;
    logic [BI_W-1:0] u_hidx, u_fidx, u_widx;
    logic [GHR_WID-1:0] u_pidx;

    always_comb begin
        u_hit  = 1'b0;
        u_hidx = '0;
        u_free = 1'b0;
        u_fidx = '0;
        for (int i = BTB_NUM - 1; i >= 0; i--) begin
            if (btb_vld[i] && btb_tag[i] == upd_pc[TAG_WID+1:2]) begin
                u_hit  = 1'b1;
                u_hidx = BI_W'(i);
            end
            if (!btb_vld[i]) begin
                u_free = 1'b1;
                u_fidx = BI_W'(i);
            end
        end
    end

    assign u_alloc = upd_valid && !u_hit && (upd_type != T_COND || upd_taken);
    assign u_we    = (upd_valid && u_hit) || u_alloc;
    assign u_widx  = u_hit ? u_hidx : (u_free ? u_fidx : victim);
    assign u_pidx  = ghr ^ upd_pc[GHR_WID+1:2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btb_vld <= '0;
            victim  <= '0;
        end else if (u_we) begin
            btb_vld[u_widx] <= 1'b1;
            if (u_alloc && !u_free) victim <= victim + BI_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (u_we) begin
            btb_tag[u_widx]  <= upd_pc[TAG_WID+1:2];
            btb_type[u_widx] <= upd_type;
            btb_tgt[u_widx]  <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
            ghr <= '0;
        end else if (upd_valid && upd_type == T_COND) begin
            pht[u_pidx] <= sat2(pht[u_pidx], upd_taken);
            ghr         <= {ghr[GHR_WID-2:0], upd_taken};
        end
    end

    // RAS: committed side trains from writeback, speculative side from accepted lookups
    logic          c_push, c_pop, s_push, s_pop;
    logic [31:0]   c_pc4;

    assign c_push = upd_valid && upd_type == T_CALL;
    assign c_pop  = upd_valid && upd_type == 2'd3;
    assign c_pc4  = upd_pc + 32'd4;
    assign s_push = acc && push_p0;
    assign s_pop  = acc && pop_p0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_ptr <= '0;
            c_cnt <= '0;
            s_ptr <= '0;
            s_cnt <= '0;
        end else begin
            c_ptr <= ras_ptr(c_ptr, c_cnt, c_push, c_pop);
            c_cnt <= ras_cnt(c_cnt, c_push, c_pop);
            if (flush) begin
                s_ptr <= ras_ptr(c_ptr, c_cnt, c_push, c_pop);
                s_cnt <= ras_cnt(c_cnt, c_push, c_pop);
            end else begin
                s_ptr <= ras_ptr(s_ptr, s_cnt, s_push, s_pop);
                s_cnt <= ras_cnt(s_cnt, s_push, s_pop);
            end
        end
    end

    // Flush copies the whole committed stack so restored pointers see matching contents
    always_ff @(posedge clk) begin
        if (c_push) c_mem[c_ptr] <= c_pc4;
        if (flush) begin
            for (int i = 0; i < RAS_DEPTH; i++)
                s_mem[i] <= (c_push && c_ptr == RP_W'(i)) ? c_pc4 : c_mem[i];
        end else if (s_push) begin
            s_mem[s_ptr] <= req_pc4;
        end
    end

    // Stage p1: registered response with valid/ready hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid   <= 1'b0;
            resp_taken   <= 1'b0;
            resp_target  <= '0;
            resp_btb_hit <= 1'b0;
        end else if (flush) begin
            resp_valid <= 1'b0;
        end else if (acc) begin
            resp_valid   <= 1'b1;
            resp_taken   <= taken_p0;
            resp_target  <= tgt_p0;
            resp_btb_hit <= hit_p0;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bpu_btb_gshare_ras.sv
// Bench for bpu_btb_gshare_ras: directed scenarios with literal pins, then random
// traffic, all checked every cycle against a queue/array reference model.
module tb_bpu_btb_gshare_ras;
    localparam int BTB_NUM = 16, TAG_WID = 12, GHR_WID = 8, RAS_DEPTH = 8;
    localparam int PHT_N = 1 << GHR_WID;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_taken, resp_btb_hit;
    logic [31:0] req_pc, resp_target, upd_pc, upd_target;
    logic [1:0]  upd_type;
    logic        upd_valid, upd_taken, flush;

    bpu_btb_gshare_ras #(.BTB_NUM(BTB_NUM), .TAG_WID(TAG_WID), .GHR_WID(GHR_WID),
                         .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_taken(resp_taken),
        .resp_target(resp_target), .resp_btb_hit(resp_btb_hit), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_type(upd_type), .upd_taken(upd_taken), .upd_target(upd_target),
        .flush(flush));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // Reference model state
    bit               m_vld [BTB_NUM];
    logic [TAG_WID-1:0] m_tag [BTB_NUM];
    int               m_type [BTB_NUM];
    logic [31:0]      m_tgt [BTB_NUM];
    int               m_victim;
    int               m_pht [PHT_N];
    int               m_ghr;
    logic [31:0]      spec_q [$];
    logic [31:0]      com_q [$];
    bit               e_valid, e_taken, e_hit;
    logic [31:0]      e_target;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int find(input logic [31:0] pc);
        for (int i = 0; i < BTB_NUM; i++)
            if (m_vld[i] && m_tag[i] == pc[TAG_WID+1:2]) return i;
        return -1;
    endfunction

    function automatic int pidx(input logic [31:0] pc);
        return (m_ghr ^ int'(pc >> 2)) & (PHT_N - 1);
    endfunction

    // One clock: model the cycle from the current inputs, then compare after the edge
    task automatic step();
        bit exp_rdy, acc, l_taken;
        int h, f, p;
        logic [31:0] l_tgt;
        #1;
        exp_rdy = (!e_valid || resp_ready) && !flush;
        chk("req_ready", req_ready, exp_rdy);
        acc = req_valid && exp_rdy;
        l_taken = 0;
        l_tgt = req_pc + 32'd4;
        h = find(req_pc);
        if (acc && h >= 0) begin
            case (m_type[h])
                0: if (m_pht[pidx(req_pc)] >= 2) begin l_taken = 1; l_tgt = m_tgt[h]; end
                1: begin l_taken = 1; l_tgt = m_tgt[h]; end
                2: begin
                    l_taken = 1; l_tgt = m_tgt[h];
                    spec_q.push_back(req_pc + 32'd4);
                    if (spec_q.size() > RAS_DEPTH) void'(spec_q.pop_front());
                end
                default: begin
                    l_taken = 1;
                    if (spec_q.size() > 0) l_tgt = spec_q.pop_back();
                    else l_tgt = m_tgt[h];
                end
            endcase
        end
        if (upd_valid) begin
            f = find(upd_pc);
            if (f >= 0) begin
                m_type[f] = int'(upd_type); m_tgt[f] = upd_target;
            end else if (upd_type != 2'd0 || upd_taken) begin
                for (int i = BTB_NUM - 1; i >= 0; i--) if (!m_vld[i]) f = i;
                if (f < 0) begin f = m_victim; m_victim = (m_victim + 1) % BTB_NUM; end
                m_vld[f] = 1; m_tag[f] = upd_pc[TAG_WID+1:2];
                m_type[f] = int'(upd_type); m_tgt[f] = upd_target;
            end
            if (upd_type == 2'd0) begin
                p = pidx(upd_pc);
                if (upd_taken && m_pht[p] < 3) m_pht[p]++;
                if (!upd_taken && m_pht[p] > 0) m_pht[p]--;
                m_ghr = ((m_ghr << 1) | int'(upd_taken)) & (PHT_N - 1);
            end
            if (upd_type == 2'd2) begin
                com_q.push_back(upd_pc + 32'd4);
                if (com_q.size() > RAS_DEPTH) void'(com_q.pop_front());
            end
            if (upd_type == 2'd3 && com_q.size() > 0) void'(com_q.pop_back());
        end
        if (flush) spec_q = com_q;
        if (flush) e_valid = 0;
        else if (acc) begin e_valid = 1; e_taken = l_taken; e_target = l_tgt; e_hit = (h >= 0); end
        else if (resp_ready) e_valid = 0;
        @(posedge clk);
        #1;
        chk("resp_valid", resp_valid, e_valid);
        if (e_valid) begin
            chk("resp_taken", resp_taken, e_taken);
            chk("resp_target", resp_target, e_target);
            chk("resp_btb_hit", resp_btb_hit, e_hit);
        end
    endtask

    task automatic idle();
        req_valid = 0; req_pc = '0; resp_ready = 1; upd_valid = 0; upd_pc = '0;
        upd_type = '0; upd_taken = 0; upd_target = '0; flush = 0;
    endtask

    task automatic train(input logic [1:0] t, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        upd_valid = 1; upd_type = t; upd_pc = pc; upd_taken = tk; upd_target = tg;
        step();
        upd_valid = 0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        req_valid = 1; req_pc = pc;
        step();
        req_valid = 0;
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] pc;
        if ($urandom_range(0, 31) == 0) return 32'hffff_fffc;
        pc = 32'h1c00_0000 + ($urandom_range(0, 23) << 2);
        if ($urandom_range(0, 7) == 0) pc = pc + 32'h4000;
        return pc;
    endfunction

    initial begin
        idle();
        for (int i = 0; i < BTB_NUM; i++) m_vld[i] = 0;
        for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
        m_ghr = 0; m_victim = 0; e_valid = 0; e_taken = 0; e_hit = 0; e_target = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_taken", resp_taken, 0);
        chk("rst_resp_target", resp_target, 0);
        chk("rst_resp_hit", resp_btb_hit, 0);

        lookup(32'h1c00_0000);
        chk("miss_valid", resp_valid, 1);
        chk("miss_taken", resp_taken, 0);
        chk("miss_target", resp_target, 32'h1c00_0004);
        chk("miss_hit", resp_btb_hit, 0);

        train(2'd1, 32'h1c00_0010, 1, 32'h1c00_0100);
        lookup(32'h1c00_0010);
        chk("jump_taken", resp_taken, 1);
        chk("jump_target", resp_target, 32'h1c00_0100);
        resp_ready = 0; req_valid = 1; req_pc = 32'h1c00_0000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_target", resp_target, 32'h1c00_0100);
            chk("hold_valid", resp_valid, 1);
            chk("hold_ready", req_ready, 0);
        end
        idle();
        step();

        // Saturate the history to all ones so later trainings reuse one PHT slot
        for (int k = 0; k < 8; k++) train(2'd0, 32'h1c00_0300, 1, 32'h1c00_0900);
        train(2'd0, 32'h1c00_0020, 1, 32'h1c00_0200);
        train(2'd0, 32'h1c00_0020, 1, 32'h1c00_0200);
        lookup(32'h1c00_0020);
        chk("cond_t_taken", resp_taken, 1);
        chk("cond_t_target", resp_target, 32'h1c00_0200);
        train(2'd0, 32'h1c00_0020, 0, 32'h1c00_0200);
        train(2'd0, 32'h1c00_0020, 0, 32'h1c00_0200);
        lookup(32'h1c00_0020);
        chk("cond_nt_taken", resp_taken, 0);
        chk("cond_nt_target", resp_target, 32'h1c00_0024);
        chk("cond_nt_hit", resp_btb_hit, 1);

        train(2'd2, 32'h1c00_0040, 1, 32'h1c00_0400);
        train(2'd3, 32'h1c00_0080, 1, 32'h1c00_0800);
        lookup(32'h1c00_0040);
        chk("call_target", resp_target, 32'h1c00_0400);
        lookup(32'h1c00_0080);
        chk("ret_ras_target", resp_target, 32'h1c00_0044);
        lookup(32'h1c00_0080);
        chk("ret_empty_target", resp_target, 32'h1c00_0800);

        for (int k = 0; k <= RAS_DEPTH; k++) train(2'd2, 32'h1c00_1000 + 32'(k * 16), 1, 32'h1c00_5000);
        for (int k = 0; k <= RAS_DEPTH; k++) lookup(32'h1c00_1000 + 32'(k * 16));
        for (int k = RAS_DEPTH; k >= 1; k--) begin
            lookup(32'h1c00_0080);
            chk("ras_lifo", resp_target, 32'h1c00_1004 + 32'(k * 16));
        end
        lookup(32'h1c00_0080);
        chk("ras_oldest_lost", resp_target, 32'h1c00_0800);

        for (int k = 0; k < RAS_DEPTH; k++) train(2'd3, 32'h1c00_0080, 1, 32'h1c00_0800);
        lookup(32'h1c00_0040);
        lookup(32'h1c00_0040);
        flush = 1;
        step();
        flush = 0;
        lookup(32'h1c00_0080);
        chk("flush_ret_target", resp_target, 32'h1c00_0800);
        req_valid = 1; req_pc = 32'h1c00_0010; flush = 1;
        #1 chk("flush_req_ready", req_ready, 0);
        step();
        chk("flush_drop_valid", resp_valid, 0);
        idle();

        train(2'd1, 32'h1c00_2000, 1, 32'h1c00_6000);
        train(2'd1, 32'h1c00_2004, 1, 32'h1c00_6004);
        train(2'd1, 32'h1c00_2008, 1, 32'h1c00_6008);
        lookup(32'h1c00_0010);
        chk("evict0_hit", resp_btb_hit, 0);
        chk("evict0_target", resp_target, 32'h1c00_0014);
        lookup(32'h1c00_2008);
        chk("alloc_hit", resp_btb_hit, 1);
        chk("alloc_target", resp_target, 32'h1c00_6008);
        train(2'd1, 32'h1c00_200c, 1, 32'h1c00_600c);
        lookup(32'h1c00_0300);
        chk("evict1_hit", resp_btb_hit, 0);
        train(2'd0, 32'h1c00_3000, 0, 32'h1c00_7000);
        lookup(32'h1c00_0020);
        chk("no_alloc_keep", resp_btb_hit, 1);
        lookup(32'h1c00_3000);
        chk("no_alloc_miss", resp_btb_hit, 0);

        for (int n = 0; n < 3000; n++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_pc     = pick_pc();
            resp_ready = ($urandom_range(0, 3) != 0);
            upd_valid  = ($urandom_range(0, 2) == 0);
            upd_pc     = pick_pc();
            upd_type   = 2'($urandom_range(0, 3));
            upd_taken  = 1'($urandom_range(0, 1));
            upd_target = $urandom;
            flush      = ($urandom_range(0, 19) == 0);
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
